// File: rtl/gpu_fill_pkg.sv
// ---------------------------------------------------------------------------
// gpu_fill_pkg
// Shared types and constants for the span fill engine:
//   fill_mode_t         - fill operation selected per job
//   state_t             - sequencing states of the engine
//   DEFAULT_LAYER_WORDS - default address offset between layer buffers
//   DEFAULT_ROW_STRIDE  - default address step between screen rows
// ---------------------------------------------------------------------------
package gpu_fill_pkg;

    typedef enum logic [1:0] {
        FILL_SPAN  = 2'd0,
        FILL_MASK  = 2'd1,
        FILL_CLEAR = 2'd2,
        FILL_RSVD  = 2'd3   // behaves as FILL_MASK
    } fill_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_MASK = 3'd1,
        ST_READ     = 3'd2,
        ST_MERGE    = 3'd3,
        ST_WRITE    = 3'd4,
        ST_NEXT     = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

    localparam int DEFAULT_LAYER_WORDS = 65536;
    localparam int DEFAULT_ROW_STRIDE  = 256;

endpackage

// File: rtl/span_merge.sv
// ---------------------------------------------------------------------------
// span_merge
// Combinational pixel merge of one SRAM word.
//   mask       - per-pixel coverage bits for the row
//   mode       - fill_mode_t encoding (SPAN / MASK / CLEAR / reserved=MASK)
//   color      - fill colour
//   read_word  - word read from the SRAM
//   write_word - merged word; pixel p at [p*PIXEL_BITS +: PIXEL_BITS]
// ---------------------------------------------------------------------------
module span_merge
    import gpu_fill_pkg::*;
#(
    parameter int PIXEL_BITS  = 24,
    parameter int SPAN_PIXELS = 64
) (
    input  logic [SPAN_PIXELS-1:0]            mask,
    input  logic [1:0]                        mode,
    input  logic [PIXEL_BITS-1:0]             color,
    input  logic [PIXEL_BITS*SPAN_PIXELS-1:0] read_word,
    output logic [PIXEL_BITS*SPAN_PIXELS-1:0] write_word
);

    genvar gi;
    generate
        for (gi = 0; gi < SPAN_PIXELS; gi++) begin : g_px
            // A pixel lies inside the lo..hi span exactly when some mask bit
            // is set at or below it and some mask bit is set at or above it.
            logic below;
            logic above;
            logic hit;
            logic [PIXEL_BITS-1:0] fill;

            assign below = |mask[gi:0];
            assign above = |mask[SPAN_PIXELS-1:gi];

            always_comb begin
                hit  = mask[gi];
                fill = color;
                case (mode)
                    FILL_SPAN:  hit  = below & above;
                    FILL_CLEAR: fill = '0;
                    default:    ;
                endcase
            end

            assign write_word[gi*PIXEL_BITS +: PIXEL_BITS] =
                hit ? fill : read_word[gi*PIXEL_BITS +: PIXEL_BITS];
        end
    endgenerate

endmodule

// File: rtl/span_fill_engine.sv
// ---------------------------------------------------------------------------
// span_fill_engine
// Row-by-row read/merge/write fill of one SRAM word per screen row.
//   clk, rst                 - clock, synchronous active-high reset
//   start + job inputs       - x_org, y_org, num_rows, layer_num, mode,
//                              color_code; latched when start is seen in IDLE
//   mask_data/valid/ready    - per-row coverage mask handshake
//   read_enable/write_enable - SRAM strobes, held until mem_done
//   address, read_data,
//   write_data               - SRAM address and word data
//   busy, done, rows_written - job status (done is a one-cycle pulse)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module span_fill_engine
    import gpu_fill_pkg::*;
#(
    parameter int ADDR_SIZE_BITS = 30,
    parameter int PIXEL_BITS     = 24,
    parameter int SPAN_PIXELS    = 64,
    parameter int MAX_ROWS       = 64,
    parameter int ROW_STRIDE     = DEFAULT_ROW_STRIDE,
    parameter int LAYER_WORDS    = DEFAULT_LAYER_WORDS,
    parameter int NUM_LAYERS     = 2,
    parameter int SCREEN_H       = 256,
    localparam int ROW_W         = $clog2(MAX_ROWS) + 1,
    localparam int LAYER_W       = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
    localparam int WORD_W        = PIXEL_BITS * SPAN_PIXELS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [7:0]                x_org,
    input  logic [7:0]                y_org,
    input  logic [ROW_W-1:0]          num_rows,
    input  logic [LAYER_W-1:0]        layer_num,
    input  logic [1:0]                mode,
    input  logic [PIXEL_BITS-1:0]     color_code,
    input  logic [SPAN_PIXELS-1:0]    mask_data,
    input  logic                      mask_valid,
    output logic                      mask_ready,
    output logic                      read_enable,
    output logic                      write_enable,
    input  logic                      mem_done,
    output logic [ADDR_SIZE_BITS-1:0] address,
    input  logic [WORD_W-1:0]         read_data,
    output logic [WORD_W-1:0]         write_data,
    output logic                      busy,
    output logic                      done,
    output logic [ROW_W-1:0]          rows_written
);

    state_t state_reg;
    state_t state_next;

    logic [7:0]             x_reg;
    logic [7:0]             y_reg;
    logic [ROW_W-1:0]       rows_reg;
    logic [ROW_W-1:0]       row_reg;
    logic [LAYER_W-1:0]     layer_reg;
    logic [1:0]             mode_reg;
    logic [PIXEL_BITS-1:0]  color_reg;
    logic [SPAN_PIXELS-1:0] mask_reg;
    logic [WORD_W-1:0]      rdata_reg;
    logic [WORD_W-1:0]      merged;

    logic [ROW_W-1:0]          rows_clamped;
    logic [ROW_W-1:0]          row_inc;
    logic [31:0]               screen_row;
    logic                      row_clipped;
    logic                      mask_beat;
    logic [ADDR_SIZE_BITS-1:0] addr_calc;

    logic busy_next;
    logic done_next;
    logic mask_ready_next;
    logic read_enable_next;
    logic write_enable_next;

    assign rows_clamped = (num_rows > ROW_W'(MAX_ROWS)) ? ROW_W'(MAX_ROWS) : num_rows;
    assign row_inc      = row_reg + ROW_W'(1);
    assign screen_row   = 32'(y_reg) + 32'(row_reg);
    // Rows past the bottom of the screen are consumed but never touch SRAM.
    assign row_clipped  = (screen_row >= 32'(SCREEN_H));
    // mask_ready is high exactly while the FSM sits in GET_MASK.
    assign mask_beat    = mask_valid && mask_ready;

    assign addr_calc = ADDR_SIZE_BITS'(layer_reg) * ADDR_SIZE_BITS'(LAYER_WORDS)
                     + ADDR_SIZE_BITS'(screen_row) * ADDR_SIZE_BITS'(ROW_STRIDE)
                     + ADDR_SIZE_BITS'(x_reg);

    span_merge #(
        .PIXEL_BITS  (PIXEL_BITS),
        .SPAN_PIXELS (SPAN_PIXELS)
    ) u_merge (
        .mask       (mask_reg),
        .mode       (mode_reg),
        .color      (color_reg),
        .read_word  (rdata_reg),
        .write_word (merged)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = (num_rows == '0) ? ST_DONE : ST_GET_MASK;
                end
            end
            ST_GET_MASK: begin
                if (mask_beat) begin
                    state_next = (row_clipped || (mask_data == '0)) ? ST_NEXT : ST_READ;
                end
            end
            ST_READ:  if (mem_done) state_next = ST_MERGE;
            ST_MERGE: state_next = ST_WRITE;
            ST_WRITE: if (mem_done) state_next = ST_NEXT;
            ST_NEXT:  state_next = (row_inc == rows_reg) ? ST_DONE : ST_GET_MASK;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // ---------------- output decode ----------------
    // Decoded from the upcoming state so the registered outputs line up
    // with the state they describe.
    always_comb begin
        busy_next         = (state_next != ST_IDLE);
        done_next         = (state_next == ST_DONE);
        mask_ready_next   = (state_next == ST_GET_MASK);
        read_enable_next  = (state_next == ST_READ);
        write_enable_next = (state_next == ST_WRITE);
    end

    // ---------------- job and datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg     <= '0;
            y_reg     <= '0;
            rows_reg  <= '0;
            row_reg   <= '0;
            layer_reg <= '0;
            mode_reg  <= '0;
            color_reg <= '0;
            mask_reg  <= '0;
            rdata_reg <= '0;
        end else begin
            if (state_reg == ST_IDLE && start) begin
                x_reg     <= x_org;
                y_reg     <= y_org;
                rows_reg  <= rows_clamped;
                row_reg   <= '0;
                layer_reg <= layer_num;
                mode_reg  <= mode;
                color_reg <= color_code;
            end
            if (mask_beat) begin
                mask_reg <= mask_data;
            end
            if (state_reg == ST_READ && mem_done) begin
                rdata_reg <= read_data;
            end
            if (state_reg == ST_NEXT) begin
                row_reg <= row_inc;
            end
        end
    end

    // ---------------- registered outputs ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            mask_ready   <= 1'b0;
            read_enable  <= 1'b0;
            write_enable <= 1'b0;
            address      <= '0;
            write_data   <= '0;
            rows_written <= '0;
        end else begin
            busy         <= busy_next;
            done         <= done_next;
            mask_ready   <= mask_ready_next;
            read_enable  <= read_enable_next;
            write_enable <= write_enable_next;
            // Address is loaded once per row and then held through READ,
            // MERGE and WRITE.
            if (state_reg == ST_GET_MASK && state_next == ST_READ) begin
                address <= addr_calc;
            end
            if (state_reg == ST_MERGE) begin
                write_data <= merged;
            end
            if (state_reg == ST_IDLE && start) begin
                rows_written <= '0;
            end else if (state_reg == ST_WRITE && mem_done) begin
                rows_written <= rows_written + ROW_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_span_fill_engine.sv
// ---------------------------------------------------------------------------
// tb_span_fill_engine
// Scoreboard bench: expected SRAM writes are queued when a job is issued and
// compared when the SRAM model completes each write.
// ---------------------------------------------------------------------------
module tb_span_fill_engine;

    localparam int AW = 30;
    localparam int PB = 24;
    localparam int SP = 64;
    localparam int MR = 64;
    localparam int RW = 7;
    localparam int WW = PB * SP;

    typedef struct {
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [7:0]    x_org = '0;
    logic [7:0]    y_org = '0;
    logic [RW-1:0] num_rows = '0;
    logic [0:0]    layer_num = '0;
    logic [1:0]    mode = '0;
    logic [PB-1:0] color_code = '0;
    logic [SP-1:0] mask_data = '0;
    logic          mask_valid = 1'b0;
    logic          mask_ready;
    logic          read_enable;
    logic          write_enable;
    logic          mem_done = 1'b0;
    logic [AW-1:0] address;
    logic [WW-1:0] read_data = '0;
    logic [WW-1:0] write_data;
    logic          busy;
    logic          done;
    logic [RW-1:0] rows_written;

    int n_tests = 0;
    int n_fail  = 0;

    wr_t           exp_q[$];
    logic [SP-1:0] mask_q[$];
    logic [SP-1:0] job_masks[$];

    int            mem_delay = 1;
    int            wait_cnt = 0;
    logic          force_done = 1'b0;
    logic [AW-1:0] addr_lat = '0;
    logic [WW-1:0] wd_lat = '0;
    logic [PB-1:0] bg = '0;

    span_fill_engine dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .x_org        (x_org),
        .y_org        (y_org),
        .num_rows     (num_rows),
        .layer_num    (layer_num),
        .mode         (mode),
        .color_code   (color_code),
        .mask_data    (mask_data),
        .mask_valid   (mask_valid),
        .mask_ready   (mask_ready),
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .mem_done     (mem_done),
        .address      (address),
        .read_data    (read_data),
        .write_data   (write_data),
        .busy         (busy),
        .done         (done),
        .rows_written (rows_written)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference merge: find lo/hi explicitly, then fill pixel by pixel.
    function automatic logic [WW-1:0] model_merge(input logic [1:0] md, input logic [SP-1:0] m,
                                                  input logic [PB-1:0] col, input logic [PB-1:0] b);
        logic [WW-1:0] w;
        int lo;
        int hi;
        lo = SP;
        hi = -1;
        for (int p = 0; p < SP; p++) begin
            if (m[p]) begin
                if (lo == SP) lo = p;
                hi = p;
            end
        end
        for (int p = 0; p < SP; p++) begin
            w[p*PB +: PB] = b;
            case (md)
                2'd0:    if (p >= lo && p <= hi) w[p*PB +: PB] = col;
                2'd2:    if (m[p]) w[p*PB +: PB] = '0;
                default: if (m[p]) w[p*PB +: PB] = col;
            endcase
        end
        return w;
    endfunction

    task automatic record_write();
        wr_t e;
        int  idx;
        if (exp_q.size() == 0) begin
            check_val("unexpected_write", 64'(address), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            idx = 0;
            for (int p = 0; p < SP; p++) begin
                if (write_data[p*PB +: PB] !== e.data[p*PB +: PB]) begin
                    idx = p;
                    break;
                end
            end
            $display("[TB] write addr=%0h px%0d=%0h", address, idx, write_data[idx*PB +: PB]);
            check_val("waddr", 64'(address), 64'(e.addr));
            check_val($sformatf("wdata_px%0d", idx), 64'(write_data[idx*PB +: PB]), 64'(e.data[idx*PB +: PB]));
        end
    endtask

    // SRAM model: completes an access mem_delay cycles after the strobe rises
    // and checks that strobe, address and data stay put while it waits.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                wait_cnt = 0;
                mem_done = force_done;
            end else begin
                check_val("rd_wr_excl", 64'(read_enable & write_enable), 64'd0);
                if (read_enable || write_enable) begin
                    wait_cnt++;
                    if (wait_cnt == 1) begin
                        addr_lat = address;
                        wd_lat   = write_data;
                    end else begin
                        check_val("addr_stable", 64'(address), 64'(addr_lat));
                        if (write_enable) check_val("wdata_stable", 64'(write_data === wd_lat), 64'd1);
                    end
                    if (read_enable) read_data = {SP{bg}};
                    mem_done = (wait_cnt >= mem_delay);
                    if (mem_done && write_enable) record_write();
                end else begin
                    wait_cnt = 0;
                    mem_done = force_done;
                end
            end
        end
    end

    // Mask source: offers the next queued mask whenever the engine is ready.
    initial begin
        forever begin
            @(negedge clk);
            if (mask_ready && !rst && mask_q.size() > 0) begin
                mask_data  = mask_q.pop_front();
                mask_valid = 1'b1;
            end else begin
                mask_valid = 1'b0;
            end
        end
    end

    task automatic run_job(input string name, input int layer, input int x, input int y, input int n,
                           input logic [1:0] md, input logic [PB-1:0] col, input logic [PB-1:0] b,
                           input int dly, input bit spurious);
        int  eff;
        int  exp_rows;
        int  dcount;
        int  left;
        bit  finished;
        wr_t e;
        eff = (n > MR) ? MR : n;
        exp_rows = 0;
        bg = b;
        mem_delay = dly;
        for (int r = 0; r < eff; r++) begin
            if (y + r < 256 && job_masks[r] != '0) begin
                e.addr = AW'(layer * 65536 + (y + r) * 256 + x);
                e.data = model_merge(md, job_masks[r], col, b);
                exp_q.push_back(e);
                exp_rows++;
            end
        end
        foreach (job_masks[i]) mask_q.push_back(job_masks[i]);
        left = job_masks.size() - eff;

        @(negedge clk);
        layer_num  = 1'(layer);
        x_org      = 8'(x);
        y_org      = 8'(y);
        num_rows   = RW'(n);
        mode       = md;
        color_code = col;
        start      = 1'b1;

        dcount = 0;
        finished = 1'b0;
        for (int c = 0; c < 4000 && !finished; c++) begin
            @(negedge clk);
            if (c == 0) begin
                start      = 1'b0;
                // Scramble job inputs: the engine must use the latched copy.
                x_org      = 8'hAA;
                y_org      = 8'h11;
                num_rows   = RW'(1);
                layer_num  = ~layer_num;
                mode       = 2'd2;
                color_code = ~col;
                check_val({name, "_busy"}, 64'(busy), 64'd1);
            end else if (spurious) begin
                start = busy && (c % 7 == 3);
            end
            if (done) dcount++;
            if (c > 0 && !busy && !start) finished = 1'b1;
        end
        start = 1'b0;
        if (!finished) check_val({name, "_timeout"}, 64'd1, 64'd0);
        check_val({name, "_done_pulses"}, 64'(dcount), 64'd1);
        check_val({name, "_rows_written"}, 64'(rows_written), 64'(exp_rows));
        check_val({name, "_writes_left"}, 64'(exp_q.size()), 64'd0);
        check_val({name, "_masks_left"}, 64'(mask_q.size()), 64'(left));
        $display("[TB] job %s rows=%0d rows_written=%0d done_pulses=%0d", name, n, rows_written, dcount);
        exp_q.delete();
        mask_q.delete();
        job_masks.delete();
    endtask

    task automatic reset_mid_write();
        wr_t e;
        bit  seen;
        job_masks = '{64'h0000_0000_0000_0F00, 64'h0000_00FF_0000_0000};
        foreach (job_masks[i]) mask_q.push_back(job_masks[i]);
        bg = 24'h0F0F0F;
        mem_delay = 1;
        e.addr = AW'(0 * 65536 + 20 * 256 + 4);
        e.data = model_merge(2'd1, job_masks[0], 24'h555555, bg);
        exp_q.push_back(e);

        @(negedge clk);
        layer_num = 1'b0; x_org = 8'd4; y_org = 8'd20; num_rows = RW'(2);
        mode = 2'd1; color_code = 24'h555555; start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            if (rows_written == RW'(1)) begin
                mem_delay = 20;
                seen = 1'b1;
            end
        end
        if (!seen) check_val("rst_row0_timeout", 64'd1, 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 300 && !seen; c++) begin
            @(negedge clk);
            if (write_enable) seen = 1'b1;
        end
        if (!seen) check_val("rst_write_timeout", 64'd1, 64'd0);
        check_val("rst_rows_before", 64'(rows_written), 64'd1);

        rst = 1'b1;
        force_done = 1'b1;
        @(negedge clk);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_write_enable", 64'(write_enable), 64'd0);
        check_val("rst_read_enable", 64'(read_enable), 64'd0);
        check_val("rst_rows_written", 64'(rows_written), 64'd0);
        check_val("rst_address", 64'(address), 64'd0);
        check_val("rst_mask_ready", 64'(mask_ready), 64'd0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_val("rst_stray_done_busy", 64'(busy | write_enable | read_enable), 64'd0);
        end
        force_done = 1'b0;
        check_val("rst_writes_left", 64'(exp_q.size()), 64'd0);
        $display("[TB] job reset_mid_write busy=%0d rows_written=%0d", busy, rows_written);
        exp_q.delete();
        mask_q.delete();
        job_masks.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_val("reset_busy", 64'(busy), 64'd0);
        check_val("reset_done", 64'(done), 64'd0);
        check_val("reset_strobes", 64'({read_enable, write_enable, mask_ready}), 64'd0);
        check_val("reset_rows_written", 64'(rows_written), 64'd0);
        check_val("reset_address", 64'(address), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        job_masks = '{64'h0000_0000_0000_0408};
        run_job("span_basic", 0, 0, 0, 1, 2'd0, 24'h123456, 24'hFFFFFF, 1, 1'b0);

        job_masks = '{64'h0000_0000_0000_0408};
        run_job("mask_basic", 0, 0, 0, 1, 2'd1, 24'h123456, 24'hFFFFFF, 1, 1'b0);

        job_masks = '{64'h0000_0000_00FF_0000, 64'h8000_0000_0000_0001, 64'h1, 64'h2};
        run_job("clip", 1, 8, 254, 4, 2'd0, 24'h0ABCDE, 24'h010203, 2, 1'b0);

        job_masks = '{64'h0000_0000_0000_F0F0, 64'h0, 64'hFFFF_0000_0000_0001};
        run_job("zero_row", 0, 5, 10, 3, 2'd2, 24'hFEDCBA, 24'h777777, 1, 1'b0);

        job_masks = '{64'h0000_0100_0000_0000, {$urandom, $urandom} | 64'h10};
        run_job("slow_mem", 1, 3, 100, 2, 2'd0, 24'h00C0DE, 24'h314159, 5, 1'b1);

        job_masks = '{{$urandom, $urandom} | 64'h1, {$urandom, $urandom} | 64'h8000_0000_0000_0000};
        run_job("reserved", 0, 200, 30, 2, 2'd3, 24'hA5A5A5, 24'h5A5A5A, 3, 1'b0);

        run_job("empty", 0, 0, 0, 0, 2'd0, 24'h111111, 24'h222222, 1, 1'b1);

        for (int i = 0; i < 70; i++) job_masks.push_back('0);
        run_job("clamp", 0, 0, 0, 70, 2'd0, 24'h111111, 24'h222222, 1, 1'b0);

        reset_mid_write();

        job_masks = '{64'h0000_0000_F000_0000, 64'h0000_0000_0000_0006};
        run_job("recover", 1, 255, 7, 2, 2'd0, 24'h13579B, 24'h000001, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/span_fill_engine.md
SPAN_FILL_ENGINE -- requirements
Module: span_fill_engine

Interface
REQ-001 Parameter ADDR_SIZE_BITS, default 30, sets the SRAM address width.
REQ-002 Parameter PIXEL_BITS, default 24, sets the colour width per pixel.
REQ-003 Parameter SPAN_PIXELS, default 64, sets the pixels per SRAM word and the mask bits per row.
REQ-004 Parameter MAX_ROWS, default 64, sets the maximum rows per job.
REQ-005 Parameter ROW_STRIDE, default 256, sets the address step between screen rows.
REQ-006 Parameter LAYER_WORDS, default 65536, sets the address offset per layer.
REQ-007 Parameter NUM_LAYERS, default 2, sets the number of layer buffers.
REQ-008 Parameter SCREEN_H, default 256, sets the number of valid screen rows.
REQ-009 Port clk, input, 1 bit: the single clock; all logic uses its rising edge.
REQ-010 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-011 Port start, input, 1 bit: job request, sampled only in IDLE.
REQ-012 Port x_org, input, 8 bits: leftmost pixel column of the span window.
REQ-013 Port y_org, input, 8 bits: first row of the job.
REQ-014 Port num_rows, input, clog2(MAX_ROWS)+1 bits: rows to process; 0 means an empty job.
REQ-015 Port layer_num, input, clog2(NUM_LAYERS) bits: target layer.
REQ-016 Port mode, input, 2 bits: 0 SPAN, 1 MASK, 2 CLEAR, 3 reserved (treated as MASK).
REQ-017 Port color_code, input, PIXEL_BITS bits: fill colour.
REQ-018 Port mask_data, input, SPAN_PIXELS bits: coverage mask for the current row.
REQ-019 Ports mask_valid (input, 1 bit) and mask_ready (output, 1 bit): row mask handshake.
REQ-020 Ports read_enable and write_enable, outputs, 1 bit each: SRAM strobes.
REQ-021 Port mem_done, input, 1 bit: the SRAM has completed the current access.
REQ-022 Port address, output, ADDR_SIZE_BITS bits: SRAM address.
REQ-023 Ports read_data (input) and write_data (output), PIXEL_BITS*SPAN_PIXELS bits each: SRAM word data.
REQ-024 Ports busy (output, 1 bit), done (output, 1 bit pulse) and rows_written (output, clog2(MAX_ROWS)+1 bits): job status.

Function
REQ-025 FSM states: IDLE, GET_MASK, READ, MERGE, WRITE, NEXT, DONE.
REQ-026 IDLE + start: latch all job inputs; clamp num_rows to MAX_ROWS; clear the row counter and rows_written; go to GET_MASK, or to DONE if num_rows is 0.
REQ-027 GET_MASK: assert mask_ready; a mask_valid&&mask_ready beat latches the mask.
REQ-028 After a mask beat, go to NEXT if y_org+row >= SCREEN_H (clipped row) or the mask is all-zero; otherwise go to READ.
REQ-029 READ: hold read_enable=1 and address stable until mem_done, then capture read_data and go to MERGE.
REQ-030 Address = layer_num*LAYER_WORDS + (y_org+row)*ROW_STRIDE + x_org, computed in ADDR_SIZE_BITS-wide unsigned arithmetic.
REQ-031 MERGE (1 cycle), SPAN mode: lo = lowest set mask bit, hi = highest set mask bit; every pixel p with lo<=p<=hi becomes color_code; all other pixels keep read_data.
REQ-032 MERGE, MASK mode: only pixels whose mask bit is set become color_code.
REQ-033 MERGE, CLEAR mode: pixels whose mask bit is set become 0.
REQ-034 A single set bit (lo==hi) writes exactly one pixel.
REQ-035 Pixel p occupies write_data[p*PIXEL_BITS +: PIXEL_BITS].
REQ-036 WRITE: hold write_enable=1, address and write_data stable until mem_done; increment rows_written; go to NEXT.
REQ-037 NEXT: row++; if row==num_rows go to DONE, else go to GET_MASK.
REQ-038 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-039 busy=1 in every state except IDLE.
REQ-040 start is ignored while busy is 1.
REQ-041 read_enable and write_enable are never asserted together.
REQ-042 mask_ready=0 outside GET_MASK.
REQ-043 All outputs are registered.
REQ-044 A clipped or empty row performs no SRAM access and does not increment rows_written.

Reset
REQ-045 rst=1 at a clock edge forces IDLE and zeroes every output and internal register, including mid-access; an outstanding mem_done is then ignored.

Structure
REQ-046 Shared package gpu_fill_pkg holds the fill_mode_t enum, the state enum, and the default SRAM map constants (LAYER_WORDS, ROW_STRIDE).
REQ-047 The combinational merge lives in sub-module span_merge (mask, mode, colour, read word -> write word).

Verification
REQ-048 Scenario: layer 0, x_org 0, y_org 0, num_rows 1, SPAN, mask bits 3 and 10 set, read_data all 0xFFFFFF, colour 0x123456 -> address 0; pixels 3..10 = 0x123456, others 0xFFFFFF; rows_written=1; one done pulse.
REQ-049 Scenario: same job in MASK mode -> only pixels 3 and 10 change.
REQ-050 Scenario: layer 1, y_org 254, x_org 8, num_rows 4, all masks non-zero -> writes at 65536+254*256+8 and 65536+255*256+8 only; rows_written=2.
REQ-051 Scenario: all-zero mask on row 1 of a 3-row job -> no SRAM access for row 1; rows_written=2.
REQ-052 Scenario: mem_done delayed 5 cycles -> strobe, address and data remain stable throughout the wait; start pulses during busy are ignored.
REQ-053 Scenario: rst asserted during WRITE -> next cycle shows IDLE, busy=0, write_enable=0, rows_written=0.
